axis_detector_writer: RTL and testbench

//  Replays timestamped detector events onto a parallel detector pulse bus.

---
 rtl/axis_detector_writer.sv | 136 +++++++++++++
 tb/tb_axis_detector_writer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_detector_writer.sv
// Detector emulator: replays timestamped AXI4-Stream hit patterns onto dout
// when the free-running local time counter reaches each event's timestamp.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | ready for the next event word (tready high while enabled)
// S_WAIT  | event held, comparing its timestamp against the time counter
// S_PULSE | hit pattern being driven, pulse counter running
module axis_detector_writer #(
  parameter int TIME_WIDTH = 62,
  parameter int DATA_WIDTH = 66
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [8:0]                       cfg,
  input  logic [TIME_WIDTH+DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [TIME_WIDTH-1:0]            sts_time,
  output logic [31:0]                      sts_late
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_PULSE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [TIME_WIDTH-1:0]   time_q, time_d;
  logic [TIME_WIDTH-1:0]   evt_time_q, evt_time_d;
  logic [DATA_WIDTH-1:0]   evt_data_q, evt_data_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [31:0]             late_q, late_d;
  logic [7:0]              cntr_q, cntr_d;
  logic                    pulse_on_q, pulse_on_d;
  logic                    tready_q, tready_d;

  logic                    en;
  logic [7:0]              len;

  assign en  = cfg[8];
  assign len = cfg[7:0];

  always_comb begin
    state_d    = state_q;
    evt_time_d = evt_time_q;
    evt_data_d = evt_data_q;
    dout_d     = dout_q;
    late_d     = late_q;
    cntr_d     = cntr_q;
    pulse_on_d = pulse_on_q;
    time_d     = en ? time_q + {{(TIME_WIDTH-1){1'b0}}, 1'b1} : '0;

    // The pulse runs on its own counter so the FSM can be back in IDLE
    // during the last pulse cycle and accept the next word early.
    if (pulse_on_q) begin
      if (cntr_q >= len) begin
        dout_d     = '0;
        pulse_on_d = 1'b0;
      end else begin
        cntr_d = cntr_q + 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid && tready_q) begin
          evt_time_d = s_axis_tdata[TIME_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
          evt_data_d = s_axis_tdata[DATA_WIDTH-1:0];
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (evt_data_q == '0) begin
          state_d = S_IDLE;
        end else if (time_q == evt_time_q) begin
          dout_d     = evt_data_q;
          cntr_d     = 8'd0;
          pulse_on_d = 1'b1;
          state_d    = (len == 8'd0) ? S_IDLE : S_PULSE;
        end else if (evt_time_q < time_q) begin
          if (late_q != 32'hFFFF_FFFF) begin
            late_d = late_q + 32'd1;
          end
          state_d = S_IDLE;
        end
      end
      S_PULSE: begin
        if (({1'b0, cntr_q} + 9'd1) >= {1'b0, len}) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (!en) begin
      state_d    = S_IDLE;
      dout_d     = '0;
      pulse_on_d = 1'b0;
    end

    tready_d = en && (state_d == S_IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      time_q     <= '0;
      evt_time_q <= '0;
      evt_data_q <= '0;
      dout_q     <= '0;
      late_q     <= '0;
      cntr_q     <= '0;
      pulse_on_q <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      evt_time_q <= evt_time_d;
      evt_data_q <= evt_data_d;
      dout_q     <= dout_d;
      late_q     <= late_d;
      cntr_q     <= cntr_d;
      pulse_on_q <= pulse_on_d;
      tready_q   <= tready_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign dout          = dout_q;
  assign sts_time      = time_q;
  assign sts_late      = late_q;

endmodule

// File: tb/tb_axis_detector_writer.sv
// Directed bench for axis_detector_writer: single, late, back-to-back, zero,
// disable, reset and backpressure scenarios with hand-computed expectations.
module tb_axis_detector_writer;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [8:0]    cfg;
  logic [127:0]  s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [65:0]   dout;
  logic [61:0]   sts_time;
  logic [31:0]   sts_late;

  int n_checks = 0;
  int n_errors = 0;

  logic [65:0] dout_log   [256];
  logic        tready_log [256];

  axis_detector_writer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg           (cfg),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .dout          (dout),
    .sts_time      (sts_time),
    .sts_late      (sts_late)
  );

  always #5 aclk = ~aclk;

  // per-timestamp history of the outputs, indexed by the local time counter
  always @(negedge aclk) begin
    if (aresetn && sts_time < 62'd256) begin
      dout_log[sts_time[7:0]]   = dout;
      tready_log[sts_time[7:0]] = s_axis_tready;
    end
  end

  task automatic check(input string tag, input logic [65:0] got, input logic [65:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_time(input logic [61:0] t);
    for (int i = 0; i < 3000 && sts_time != t; i++) tick();
    if (sts_time != t) check("wait_time_timeout", {4'd0, sts_time}, {4'd0, t});
  endtask

  // leaves tvalid high after the handshake so queued words can follow
  task automatic send(input logic [61:0] t, input logic [65:0] d);
    bit done;
    done = 1'b0;
    s_axis_tdata  = {t, d};
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      if (s_axis_tready) done = 1'b1;
      tick();
    end
    if (!done) check("send_timeout", 66'd0, 66'd1);
  endtask

  task automatic do_reset();
    aresetn       = 1'b0;
    cfg           = 9'h000;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    tick();
    aresetn = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    aresetn       = 1'b0;
    cfg           = 9'h000;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    #12;
    check("rst_dout",   dout,                 66'd0);
    check("rst_tready", {65'd0, s_axis_tready}, 66'd0);
    check("rst_time",   {4'd0, sts_time},     66'd0);
    check("rst_late",   {34'd0, sts_late},    66'd0);
    tick();
    aresetn = 1'b1;
    tick();
    check("disabled_time", {4'd0, sts_time}, 66'd0);

    // single event: time=100, 5-cycle pulse
    cfg = 9'h104;
    wait_time(62'd10);
    send(62'd100, 66'h5);
    s_axis_tvalid = 1'b0;
    wait_time(62'd108);
    check("single_t100", dout_log[100], 66'h0);
    for (int t = 101; t <= 105; t++) check("single_pulse", dout_log[t], 66'h5);
    check("single_t106", dout_log[106], 66'h0);
    check("single_late", {34'd0, sts_late}, 66'd0);

    // late event: time=5 accepted at sts_time=20
    cfg = 9'h004;
    tick();
    tick();
    check("disable_time", {4'd0, sts_time}, 66'd0);
    cfg = 9'h104;
    wait_time(62'd20);
    send(62'd5, 66'h9);
    s_axis_tvalid = 1'b0;
    check("late_tready_wait", {65'd0, s_axis_tready}, 66'd0);
    tick();
    check("late_tready_back", {65'd0, s_axis_tready}, 66'd1);
    check("late_count",       {34'd0, sts_late},      66'd1);
    check("late_dout",        dout,                   66'd0);

    // asynchronous reset in the middle of a long pulse
    cfg = 9'h1FF;
    send(62'd30, 66'h3);
    s_axis_tvalid = 1'b0;
    wait_time(62'd35);
    check("pre_reset_dout", dout, 66'h3);
    #2;
    aresetn = 1'b0;
    #1;
    check("midrst_dout",   dout,                   66'd0);
    check("midrst_late",   {34'd0, sts_late},      66'd0);
    check("midrst_tready", {65'd0, s_axis_tready}, 66'd0);
    check("midrst_time",   {4'd0, sts_time},       66'd0);
    tick();
    aresetn = 1'b1;

    // back-to-back single-cycle pulses at 51 and 53
    cfg = 9'h100;
    wait_time(62'd40);
    send(62'd50, 66'h3);
    send(62'd52, 66'hA);
    s_axis_tvalid = 1'b0;
    wait_time(62'd56);
    check("b2b_wait_tready", {65'd0, tready_log[45]}, 66'd0);
    check("b2b_t50", dout_log[50], 66'h0);
    check("b2b_t51", dout_log[51], 66'h3);
    check("b2b_t52", dout_log[52], 66'h0);
    check("b2b_t53", dout_log[53], 66'hA);
    check("b2b_t54", dout_log[54], 66'h0);
    check("b2b_late", {34'd0, sts_late}, 66'd0);

    // zero pattern is dropped silently
    send(62'd60, 66'h0);
    s_axis_tvalid = 1'b0;
    wait_time(62'd65);
    check("zero_t60",   dout_log[60], 66'h0);
    check("zero_t61",   dout_log[61], 66'h0);
    check("zero_late",  {34'd0, sts_late}, 66'd0);
    check("zero_tready", {65'd0, s_axis_tready}, 66'd1);

    // disable while waiting discards the event
    send(62'd200, 66'h7);
    s_axis_tvalid = 1'b0;
    tick();
    cfg = 9'h000;
    tick();
    tick();
    check("dis_time",   {4'd0, sts_time},       66'd0);
    check("dis_tready", {65'd0, s_axis_tready}, 66'd0);
    check("dis_dout",   dout,                   66'd0);
    cfg = 9'h100;
    wait_time(62'd205);
    for (int t = 199; t <= 202; t++) check("dis_no_replay", dout_log[t], 66'h0);
    check("dis_late", {34'd0, sts_late}, 66'd0);

    // backpressure: three words queued behind a held tvalid
    do_reset();
    cfg = 9'h101;
    send(62'd30, 66'h1);
    send(62'd33, 66'h2);
    send(62'd36, 66'h4);
    s_axis_tvalid = 1'b0;
    wait_time(62'd60);
    check("bp_tready_wait",  {65'd0, tready_log[20]}, 66'd0);
    check("bp_tready_pulse", {65'd0, tready_log[31]}, 66'd0);
    check("bp_t30", dout_log[30], 66'h0);
    check("bp_t31", dout_log[31], 66'h1);
    check("bp_t32", dout_log[32], 66'h1);
    check("bp_t33", dout_log[33], 66'h0);
    check("bp_t34", dout_log[34], 66'h2);
    check("bp_t35", dout_log[35], 66'h2);
    check("bp_t36", dout_log[36], 66'h0);
    check("bp_t37", dout_log[37], 66'h4);
    check("bp_t38", dout_log[38], 66'h4);
    check("bp_t39", dout_log[39], 66'h0);
    for (int t = 40; t <= 59; t++) check("bp_quiet", dout_log[t], 66'h0);
    check("bp_late", {34'd0, sts_late}, 66'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
